// File: rtl/spot_finder_pkg.sv
// Shared definitions for the spot-finder scheduler slice.
//   - sched_state_t : scheduler FSM encoding
//   - ROI_BITS      : width of one ROI record from the finder
//   - address widths for the finder side and the ping-pong memory side
package spot_finder_pkg;
    localparam int ROI_BITS         = 40;
    localparam int NUM_ROIS_MAX_DEF = 10;
    localparam int FINDER_ADDR_W    = 14;
    localparam int MEM_ADDR_W       = 15;
    localparam int WD_W             = 21;   // shared start-wait / watchdog counter

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_DONE,
        ST_ABORT
    } sched_state_t;
endpackage

// File: rtl/spot_finder_scheduler_if.sv
// Result handshake between the scheduler (master) and the result consumer (slave).
//   result_valid    : held result present
//   result_ack      : consumer takes the held result
//   result_num_rois : ROI count of the held result
//   result_rois     : ROI records of the held result
interface spot_finder_scheduler_if
    import spot_finder_pkg::*;
#(
    parameter int num_rois_max = NUM_ROIS_MAX_DEF
);
    logic                             result_valid;
    logic                             result_ack;
    logic [7:0]                       result_num_rois;
    logic [num_rois_max*ROI_BITS-1:0] result_rois;

    modport master (
        output result_valid, result_num_rois, result_rois,
        input  result_ack
    );

    modport slave (
        input  result_valid, result_num_rois, result_rois,
        output result_ack
    );
endinterface

// File: rtl/spot_finder_scheduler_bank_tracker.sv
// spot_bank_tracker: ping-pong bank bookkeeping for the camera writer / finder pair.
//   clk_in, reset    : clock, async active-high reset
//   cam_frame_done   : writer finished a frame into wr_bank
//   rd_clear         : analysis of the read bank is finished (done or aborted)
//   wr_bank          : bank the writer must fill
//   rd_full          : bank ~wr_bank holds a complete, unanalysed frame
//   frames_dropped   : saturating count of frames lost while both banks were busy
module spot_bank_tracker (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        cam_frame_done,
    input  logic        rd_clear,
    output logic        wr_bank,
    output logic        rd_full,
    output logic [15:0] frames_dropped
);
    // A clear in the same cycle frees the read bank first, so a coincident
    // frame is accepted instead of dropped.
    logic full_eff;
    assign full_eff = rd_full & ~rd_clear;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            wr_bank        <= 1'b0;
            rd_full        <= 1'b0;
            frames_dropped <= 16'h0000;
        end else if (cam_frame_done && !full_eff) begin
            wr_bank <= ~wr_bank;
            rd_full <= 1'b1;
        end else begin
            if (rd_clear)
                rd_full <= 1'b0;
            if (cam_frame_done && frames_dropped != 16'hFFFF)
                frames_dropped <= frames_dropped + 16'd1;
        end
    end
endmodule

// File: rtl/spot_finder_scheduler.sv
// spot_finder_scheduler: runs main_spot_finder against a ping-pong bank pair.
//   clk_in, reset         : clock, async active-high reset
//   enable                : allow new analyses to start
//   cam_frame_done        : writer finished a frame into wr_bank
//   wr_bank               : bank the writer fills
//   finder_mem_address    : finder read address
//   mem_rd_address        : {~wr_bank, finder_mem_address}
//   finder_reset          : holds the finder idle when high
//   finder_analysis_rdy   : finder done pulse; finder_num_rois / finder_rois valid with it
//   res (master)          : held result with valid/ack handshake
//   frames_dropped        : saturating dropped-frame count
//   timeout_err           : sticky watchdog error
//   busy                  : analysis in progress (START or RUN)
module spot_finder_scheduler
    import spot_finder_pkg::*;
#(
    parameter int num_rois_max   = NUM_ROIS_MAX_DEF,
    parameter int timeout_cycles = 1048576,
    parameter int start_wait     = 2
) (
    input  logic                             clk_in,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             cam_frame_done,
    output logic                             wr_bank,
    input  logic [FINDER_ADDR_W-1:0]         finder_mem_address,
    output logic [MEM_ADDR_W-1:0]            mem_rd_address,
    output logic                             finder_reset,
    input  logic                             finder_analysis_rdy,
    input  logic [7:0]                       finder_num_rois,
    input  logic [num_rois_max*ROI_BITS-1:0] finder_rois,
    spot_finder_scheduler_if.master          res,
    output logic [15:0]                      frames_dropped,
    output logic                             timeout_err,
    output logic                             busy
);
    localparam logic [WD_W-1:0] START_LAST = WD_W'(start_wait - 1);
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(timeout_cycles - 1);

    sched_state_t    state, state_nxt;
    logic [WD_W-1:0] cnt;
    logic            rd_full;
    logic            capture, abort_go, rd_clear;

    // The finder result is valid for one cycle only, so capture and the
    // bank release both happen on the edge that samples rdy in RUN.
    assign capture  = (state == ST_RUN) && finder_analysis_rdy;
    assign abort_go = (state == ST_RUN) && !finder_analysis_rdy && (cnt == WD_LAST);
    assign rd_clear = capture | abort_go;

    // Bank bit is stable while analysing: wr_bank only moves with rd_full=0.
    assign mem_rd_address = {~wr_bank, finder_mem_address};

    spot_bank_tracker u_bank (
        .clk_in         (clk_in),
        .reset          (reset),
        .cam_frame_done (cam_frame_done),
        .rd_clear       (rd_clear),
        .wr_bank        (wr_bank),
        .rd_full        (rd_full),
        .frames_dropped (frames_dropped)
    );

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        finder_reset = 1'b1;
        busy         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && rd_full && (!res.result_valid || res.result_ack))
                    state_nxt = ST_START;
            end
            ST_START: begin
                // rdy may still be high from the previous frame; not sampled here
                finder_reset = 1'b0;
                busy         = 1'b1;
                if (cnt == START_LAST)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                finder_reset = 1'b0;
                busy         = 1'b1;
                if (capture)
                    state_nxt = ST_DONE;
                else if (abort_go)
                    state_nxt = ST_ABORT;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            ST_ABORT: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // One counter serves as the START delay and the RUN watchdog; it restarts
    // on every state change.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (state_nxt != state)
            cnt <= '0;
        else if (busy)
            cnt <= cnt + WD_W'(1);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            res.result_valid    <= 1'b0;
            res.result_num_rois <= 8'h00;
            res.result_rois     <= '0;
            timeout_err         <= 1'b0;
        end else begin
            if (capture) begin
                res.result_valid    <= 1'b1;
                res.result_num_rois <= finder_num_rois;
                res.result_rois     <= finder_rois;
            end else if (res.result_ack) begin
                res.result_valid <= 1'b0;
            end
            if (abort_go)
                timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spot_finder_scheduler.sv
// Self-checking bench for spot_finder_scheduler: cycle vector table for the
// main flow, then hand sequences for watchdog, drop saturation and async reset.
module tb_spot_finder_scheduler;
    import spot_finder_pkg::*;

    localparam int NR = 10;
    localparam int RW = NR * ROI_BITS;

    logic          clk_in = 1'b0;
    logic          reset  = 1'b0;
    logic          enable = 1'b0;
    logic          cam_frame_done = 1'b0;
    logic          wr_bank;
    logic [13:0]   finder_mem_address = 14'h0;
    logic [14:0]   mem_rd_address;
    logic          finder_reset;
    logic          finder_analysis_rdy = 1'b0;
    logic [7:0]    finder_num_rois = 8'h0;
    logic [RW-1:0] finder_rois = '0;
    logic [15:0]   frames_dropped;
    logic          timeout_err;
    logic          busy;
    logic [RW-1:0] rois_pat;

    int n_err = 0;
    int n_chk = 0;

    spot_finder_scheduler_if #(.num_rois_max(NR)) rif ();

    spot_finder_scheduler #(
        .num_rois_max   (NR),
        .timeout_cycles (100),
        .start_wait     (2)
    ) dut (
        .clk_in              (clk_in),
        .reset               (reset),
        .enable              (enable),
        .cam_frame_done      (cam_frame_done),
        .wr_bank             (wr_bank),
        .finder_mem_address  (finder_mem_address),
        .mem_rd_address      (mem_rd_address),
        .finder_reset        (finder_reset),
        .finder_analysis_rdy (finder_analysis_rdy),
        .finder_num_rois     (finder_num_rois),
        .finder_rois         (finder_rois),
        .res                 (rif),
        .frames_dropped      (frames_dropped),
        .timeout_err         (timeout_err),
        .busy                (busy)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct packed {
        logic       en, cfd, rdy, ack;
        logic [7:0] nroi;
        logic       wb, fr, busy, rv;
        logic [7:0] rnum;
        logic [15:0] drop;
    } vec_t;

    vec_t tv [0:16];

    function automatic vec_t mk(logic en, logic cfd, logic rdy, logic ack, logic [7:0] nroi,
                                logic wb, logic fr, logic bz, logic rv, logic [7:0] rnum,
                                logic [15:0] drop);
        vec_t v;
        v.en = en; v.cfd = cfd; v.rdy = rdy; v.ack = ack; v.nroi = nroi;
        v.wb = wb; v.fr = fr; v.busy = bz; v.rv = rv; v.rnum = rnum; v.drop = drop;
        return v;
    endfunction

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        int n;
        logic [13:0] addr;

        for (int k = 0; k < NR; k++)
            rois_pat[k*ROI_BITS +: ROI_BITS] = 40'h12_3456_7800 + 40'(k * 17 + 1);

        //          en cfd rdy ack nroi   wb fr bz rv rnum drop
        tv[0]  = mk(1, 1,  0,  0,  8'd0,  1, 1, 0, 0, 8'd0, 16'd0); // frame accepted
        tv[1]  = mk(1, 0,  0,  0,  8'd0,  1, 0, 1, 0, 8'd0, 16'd0); // -> START
        tv[2]  = mk(1, 0,  1,  0,  8'd0,  1, 0, 1, 0, 8'd0, 16'd0); // stale rdy ignored
        tv[3]  = mk(1, 0,  1,  0,  8'd0,  1, 0, 1, 0, 8'd0, 16'd0); // -> RUN
        tv[4]  = mk(1, 0,  1,  0,  8'd3,  1, 1, 0, 1, 8'd3, 16'd0); // first RUN rdy taken
        tv[5]  = mk(1, 0,  0,  0,  8'd0,  1, 1, 0, 1, 8'd3, 16'd0); // DONE -> IDLE
        tv[6]  = mk(1, 1,  0,  0,  8'd0,  0, 1, 0, 1, 8'd3, 16'd0); // second frame
        tv[7]  = mk(1, 0,  0,  0,  8'd0,  0, 1, 0, 1, 8'd3, 16'd0); // held result blocks
        tv[8]  = mk(1, 0,  0,  0,  8'd0,  0, 1, 0, 1, 8'd3, 16'd0);
        tv[9]  = mk(1, 0,  0,  1,  8'd0,  0, 0, 1, 0, 8'd3, 16'd0); // ack -> START
        tv[10] = mk(1, 1,  0,  0,  8'd0,  0, 0, 1, 0, 8'd3, 16'd1); // drops while busy
        tv[11] = mk(1, 1,  0,  0,  8'd0,  0, 0, 1, 0, 8'd3, 16'd2);
        tv[12] = mk(1, 1,  0,  0,  8'd0,  0, 0, 1, 0, 8'd3, 16'd3);
        tv[13] = mk(1, 1,  1,  0,  8'd7,  1, 1, 0, 1, 8'd7, 16'd3); // frame + DONE collide
        tv[14] = mk(0, 0,  0,  0,  8'd0,  1, 1, 0, 1, 8'd7, 16'd3);
        tv[15] = mk(0, 0,  0,  1,  8'd0,  1, 1, 0, 0, 8'd7, 16'd3); // ack, enable low
        tv[16] = mk(0, 0,  0,  0,  8'd0,  1, 1, 0, 0, 8'd7, 16'd3);

        // reset state
        addr = 14'h2A5;
        finder_mem_address = addr;
        #1 reset = 1'b1;
        step();
        step();
        chk("rst wr_bank", wr_bank, 0);
        chk("rst finder_reset", finder_reset, 1);
        chk("rst busy", busy, 0);
        chk("rst result_valid", rif.result_valid, 0);
        chk("rst result_num_rois", rif.result_num_rois, 0);
        chk("rst result_rois", rif.result_rois, 0);
        chk("rst frames_dropped", frames_dropped, 0);
        chk("rst timeout_err", timeout_err, 0);
        chk("rst mem_rd_address", mem_rd_address, {1'b1, addr});
        reset = 1'b0;

        // main flow vectors
        for (int i = 0; i < 17; i++) begin
            enable              = tv[i].en;
            cam_frame_done      = tv[i].cfd;
            finder_analysis_rdy = tv[i].rdy;
            finder_num_rois     = tv[i].nroi;
            finder_rois         = tv[i].rdy ? rois_pat : '0;
            rif.result_ack      = tv[i].ack;
            addr                = 14'(i * 613 + 5);
            finder_mem_address  = addr;
            step();
            chk($sformatf("v%0d wr_bank", i), wr_bank, tv[i].wb);
            chk($sformatf("v%0d finder_reset", i), finder_reset, tv[i].fr);
            chk($sformatf("v%0d busy", i), busy, tv[i].busy);
            chk($sformatf("v%0d result_valid", i), rif.result_valid, tv[i].rv);
            chk($sformatf("v%0d result_num_rois", i), rif.result_num_rois, tv[i].rnum);
            chk($sformatf("v%0d frames_dropped", i), frames_dropped, tv[i].drop);
            chk($sformatf("v%0d timeout_err", i), timeout_err, 0);
            chk($sformatf("v%0d mem_rd_address", i), mem_rd_address, {~tv[i].wb, addr});
        end
        chk("tbl result_rois", rif.result_rois, rois_pat);
        finder_rois    = '0;
        rif.result_ack = 1'b0;

        // watchdog: pending frame, no rdy
        enable = 1'b1;
        step();
        enable = 1'b0;
        step();
        step();
        chk("to in RUN busy", busy, 1);
        n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
        chk("to RUN cycles", n, 100);
        chk("to timeout_err", timeout_err, 1);
        chk("to finder_reset", finder_reset, 1);
        chk("to result_valid", rif.result_valid, 0);
        chk("to result_num_rois", rif.result_num_rois, 7);
        step();
        cam_frame_done = 1'b1;
        step();
        cam_frame_done = 1'b0;
        chk("to rd_full cleared wr_bank", wr_bank, 0);
        chk("to frames_dropped", frames_dropped, 3);

        // drop counter saturation (bank full, enable low)
        cam_frame_done = 1'b1;
        repeat (65532) step();
        chk("sat reach", frames_dropped, 16'hFFFF);
        repeat (8) step();
        chk("sat hold", frames_dropped, 16'hFFFF);
        chk("sat wr_bank", wr_bank, 0);
        cam_frame_done = 1'b0;

        // capture a result, then get back into RUN and reset asynchronously
        enable = 1'b1;
        step();
        step();
        step();
        finder_analysis_rdy = 1'b1;
        finder_num_rois     = 8'd5;
        finder_rois         = rois_pat;
        step();
        finder_analysis_rdy = 1'b0;
        finder_rois         = '0;
        finder_num_rois     = 8'd0;
        chk("cap result_valid", rif.result_valid, 1);
        chk("cap result_num_rois", rif.result_num_rois, 5);
        chk("cap result_rois", rif.result_rois, rois_pat);
        step();
        cam_frame_done = 1'b1;
        step();
        cam_frame_done = 1'b0;
        rif.result_ack = 1'b1;
        step();
        rif.result_ack = 1'b0;
        step();
        step();
        step();
        chk("pre-rst busy", busy, 1);
        chk("pre-rst wr_bank", wr_bank, 1);
        addr = 14'h1ABC;
        finder_mem_address = addr;
        #2 reset = 1'b1;
        #1;
        chk("arst finder_reset", finder_reset, 1);
        chk("arst busy", busy, 0);
        chk("arst result_valid", rif.result_valid, 0);
        chk("arst result_num_rois", rif.result_num_rois, 0);
        chk("arst result_rois", rif.result_rois, 0);
        chk("arst wr_bank", wr_bank, 0);
        chk("arst frames_dropped", frames_dropped, 0);
        chk("arst timeout_err", timeout_err, 0);
        chk("arst mem_rd_address", mem_rd_address, {1'b1, addr});
        @(negedge clk_in);
        reset = 1'b0;
        step();
        step();
        chk("post-rst busy", busy, 0);
        chk("post-rst finder_reset", finder_reset, 1);
        chk("post-rst wr_bank", wr_bank, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
